sap_run_controller: RTL

- Front-panel run controller for the SAP-1 processor.
- Holds the processor in reset while the operator loads RAM from switches.
- Runs the processor free-running or one instruction per step, and stops it on HLT.
- Drives the processor clock enable and reset, and mirrors the T-state count so it knows where instruction boundaries fall.

---
 rtl/sap_pkg.sv | 15 +
 rtl/sap_btn_sync.sv | 15 +
 rtl/sap_run_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared mode encoding and SAP-1 timing/opcode constants for the run controller.
package sap_pkg;
  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_PROG   = 3'd1,
    MODE_RUN    = 3'd2,
    MODE_STEP   = 3'd3,
    MODE_HALTED = 3'd4
  } mode_t;
  localparam logic [2:0] T_LAST     = 3'd6;
  localparam logic [3:0] HLT_OPCODE = 4'hF;
  localparam logic [2:0] HLT_TSTATE = 3'd3;
  localparam int         ADDR_W     = 4;
  localparam int         DATA_W     = 8;
endpackage

// File: rtl/sap_btn_sync.sv
// sap_btn_sync: 2-flop synchronizer with a third flop for rising-edge detection.
module sap_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_sync,
  output logic o_rise
);
  logic [2:0] r_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sh <= '0;
    else        r_sh <= {r_sh[1:0], i_btn};
  assign o_sync = r_sh[1];
  assign o_rise = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/sap_run_controller.sv
// sap_run_controller: SAP-1 front-panel controller for RAM loading, run/step/stop and HLT detection.
module sap_run_controller
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic              run_btn,
  input  logic              step_btn,
  input  logic              prog_mode,
  input  logic              prog_wr_btn,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        t_state,
  output logic [2:0]        mode
);
  logic w_run_s, w_run_r, w_step_s, w_step_r, w_wr_s, w_wr_r, w_prog_s, w_prog_r;
  logic w_run, w_step, w_wr, w_prog;
  mode_t r_mode, w_mode_nx;
  logic [2:0] r_t, w_t_nx;
  logic r_stop, w_stop_nx, r_cpu_en, w_en_nx, r_cpu_rst_n, w_rst_n_nx, r_ram_we, w_we_nx;
  logic w_halt, w_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  sap_btn_sync u_run  (.clk(clk), .rst_n(reset), .i_btn(run_btn),     .o_sync(w_run_s),  .o_rise(w_run_r));
  sap_btn_sync u_step (.clk(clk), .rst_n(reset), .i_btn(step_btn),    .o_sync(w_step_s), .o_rise(w_step_r));
  sap_btn_sync u_wr   (.clk(clk), .rst_n(reset), .i_btn(prog_wr_btn), .o_sync(w_wr_s),   .o_rise(w_wr_r));
  sap_btn_sync u_prog (.clk(clk), .rst_n(reset), .i_btn(prog_mode),   .o_sync(w_prog_s), .o_rise(w_prog_r));

  // a rise always coincides with its synchronized level, so these terms are exact
  assign w_run  = w_run_r & w_run_s;
  assign w_step = w_step_r & w_step_s;
  assign w_wr   = w_wr_r & w_wr_s;
  assign w_prog = w_prog_s | w_prog_r;

  assign w_halt = (r_mode == MODE_RUN || r_mode == MODE_STEP) && r_t == HLT_TSTATE && opcode == HLT_OPCODE;
  assign w_last = r_cpu_en && r_t == T_LAST;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mode      <= MODE_IDLE;
      r_t         <= '0;
      r_stop      <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_ram_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_mode      <= w_mode_nx;
      r_t         <= w_t_nx;
      r_stop      <= w_stop_nx;
      r_cpu_en    <= w_en_nx;
      r_cpu_rst_n <= w_rst_n_nx;
      r_ram_we    <= w_we_nx;
      if (w_we_nx) begin
        r_addr  <= prog_addr;
        r_wdata <= prog_data;
      end
    end

  always_comb begin
    w_mode_nx = r_mode;
    case (r_mode)
      MODE_IDLE:   w_mode_nx = w_prog ? MODE_PROG : w_run ? MODE_RUN : w_step ? MODE_STEP : MODE_IDLE;
      MODE_PROG:   w_mode_nx = w_prog ? MODE_PROG : MODE_IDLE;
      MODE_RUN:    w_mode_nx = w_halt ? MODE_HALTED : (w_last && r_stop) ? MODE_IDLE : MODE_RUN;
      MODE_STEP:   w_mode_nx = w_halt ? MODE_HALTED : w_last ? MODE_IDLE : MODE_STEP;
      MODE_HALTED: w_mode_nx = w_prog ? MODE_PROG : MODE_HALTED;
      default:     w_mode_nx = MODE_IDLE;
    endcase
    w_t_nx    = (w_mode_nx == MODE_PROG) ? 3'd0 : (!r_cpu_en || w_halt) ? r_t : (r_t == T_LAST) ? 3'd0 : r_t + 3'd1;
    w_stop_nx = r_mode == MODE_RUN && w_mode_nx == MODE_RUN && (r_stop || w_run);
  end

  // cpu_en is registered, so it is decided one cycle ahead from the next mode and T-state
  always_comb begin
    w_en_nx    = (w_mode_nx == MODE_RUN || w_mode_nx == MODE_STEP) && !(w_t_nx == HLT_TSTATE && opcode == HLT_OPCODE);
    w_rst_n_nx = w_mode_nx != MODE_PROG;
    w_we_nx    = r_mode == MODE_PROG && w_wr;
  end

  assign cpu_en    = r_cpu_en;
  assign cpu_rst_n = r_cpu_rst_n;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign t_state   = r_t;
  assign mode      = r_mode;
endmodule
